// File: rtl/axis_frame_reader.sv
// axis_frame_reader: raster-order frame reader from a sync-read RAM onto an AXI-Stream master.
// Optional tlast/tuser sideband generation is enabled by defining AXIS_FRAME_READER_SIDEBAND_EN.
module axis_frame_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              config_pulse,
    input  logic [15:0]       config_width,
    input  logic [15:0]       config_height,
    input  logic [ADDR_W-1:0] config_base,
    input  logic [ADDR_W-1:0] config_stride,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_axis_pix_tdata,
    output logic              m_axis_pix_tvalid,
    input  logic              m_axis_pix_tready,
    output logic              m_axis_pix_tlast,
    output logic              m_axis_pix_tuser
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state, state_nx;
    logic [15:0] w_last, h_last, w, h;
    logic [ADDR_W-1:0] stride, row_base;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0] occ;
    logic inflight, wr_ptr, rd_ptr, pop, start, line_end, frame_end;
    assign pop = m_axis_pix_tvalid && m_axis_pix_tready;
    assign start = config_pulse && config_width != 16'd0 && config_height != 16'd0;
    assign line_end = w == w_last;
    assign frame_end = line_end && h == h_last;
    assign done = state == IDLE;
    assign mem_rd_addr = row_base + ADDR_W'(w);
    assign m_axis_pix_tvalid = occ != 2'd0;
    assign m_axis_pix_tdata = fifo_data[rd_ptr];
    // occ + inflight is the number of slots already claimed; a pop this cycle frees one
    always_comb begin
        state_nx = state;
        mem_rd_en = state == READ && (occ + {1'b0, inflight} - {1'b0, pop}) < 2'd2;
        case (state)
            IDLE:    state_nx = start ? READ : IDLE;
            READ:    state_nx = mem_rd_en && frame_end ? DRAIN : READ;
            DRAIN:   state_nx = pop && occ + {1'b0, inflight} == 2'd1 ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w_last <= '0;
            h_last <= '0;
            w <= '0;
            h <= '0;
            stride <= '0;
            row_base <= '0;
            inflight <= 1'b0;
            occ <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            state <= state_nx;
            inflight <= mem_rd_en;
            if (state == IDLE && start) begin
                w_last <= config_width - 16'd1;
                h_last <= config_height - 16'd1;
                stride <= config_stride;
                row_base <= config_base;
                w <= '0;
                h <= '0;
            end else if (mem_rd_en) begin
                w <= line_end ? 16'd0 : w + 16'd1;
                h <= line_end ? h + 16'd1 : h;
                row_base <= line_end ? row_base + stride : row_base;
            end
            if (inflight) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end
`ifdef AXIS_FRAME_READER_SIDEBAND_EN
    logic pend_last, pend_user;
    logic [1:0] fifo_last, fifo_user;
    // flags are sampled at issue and ride alongside the read for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_last <= 1'b0;
            pend_user <= 1'b0;
            fifo_last <= '0;
            fifo_user <= '0;
        end else begin
            pend_last <= line_end;
            pend_user <= w == 16'd0 && h == 16'd0;
            if (inflight) begin
                fifo_last[wr_ptr] <= pend_last;
                fifo_user[wr_ptr] <= pend_user;
            end
        end
    end
    assign m_axis_pix_tlast = m_axis_pix_tvalid && fifo_last[rd_ptr];
    assign m_axis_pix_tuser = m_axis_pix_tvalid && fifo_user[rd_ptr];
`else
    assign m_axis_pix_tlast = 1'b0;
    assign m_axis_pix_tuser = 1'b0;
`endif
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inflight && occ == 2'd2));
endmodule
